// File: rtl/if_fetch.sv
// Fetch-stage control: owns the F-stage PC, issues one instruction read at a time
// over a req/addr_ok/data_ok interface and holds the fetched word until decode takes it.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc_in,
   input  logic        flush,
   input  logic        id_allowin,
   output logic [31:0] pc_out,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        if_adel
);

   typedef enum logic [1:0] {
      S_REQ    = 2'd0,
      S_WAIT   = 2'd1,
      S_VALID  = 2'd2,
      S_CANCEL = 2'd3
   } state_t;

   state_t state;
   logic   misaligned;
   logic   accepted;

   assign misaligned = |pc_out[1:0];
   assign inst_req   = (state == S_REQ) && !misaligned && !rst;
   assign inst_addr  = pc_out;
   // addr_ok only counts when a request was actually presented
   assign accepted   = inst_req && inst_addr_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_REQ;
         pc_out   <= RESET_PC;
         if_valid <= 1'b0;
         if_inst  <= 32'h0;
         if_pc    <= RESET_PC;
         if_adel  <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (flush) begin
                  pc_out <= npc_in;
                  state  <= accepted ? S_CANCEL : S_REQ;
               end else if (misaligned) begin
                  state    <= S_VALID;
                  if_valid <= 1'b1;
                  if_adel  <= 1'b1;
                  if_inst  <= 32'h0;
                  if_pc    <= pc_out;
               end else if (accepted) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (flush) begin
                  pc_out <= npc_in;
                  state  <= inst_data_ok ? S_REQ : S_CANCEL;
               end else if (inst_data_ok) begin
                  state    <= S_VALID;
                  if_valid <= 1'b1;
                  if_adel  <= 1'b0;
                  if_inst  <= inst_rdata;
                  if_pc    <= pc_out;
               end
            end
            S_VALID: begin
               if (flush || id_allowin) begin
                  pc_out   <= npc_in;
                  if_valid <= 1'b0;
                  state    <= S_REQ;
               end
            end
            S_CANCEL: begin
               // the cancelled response is swallowed; if_* keep their old contents
               if (flush) pc_out <= npc_in;
               if (inst_data_ok) state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs change on the falling edge, outputs are
// checked 1 ns later against hand-computed values.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc_in;
   logic        flush;
   logic        id_allowin;
   logic [31:0] pc_out;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_adel;

   int n_checks = 0;
   int n_pass   = 0;

   if_fetch #(.RESET_PC(32'hBFC00000)) dut (
      .clk          (clk),
      .rst          (rst),
      .npc_in       (npc_in),
      .flush        (flush),
      .id_allowin   (id_allowin),
      .pc_out       (pc_out),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .if_valid     (if_valid),
      .if_inst      (if_inst),
      .if_pc        (if_pc),
      .if_adel      (if_adel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // advance through one rising edge, landing on the next falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; npc_in = 32'hBFC00004; flush = 1'b0; id_allowin = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
      tick(); tick();
      #1;
      chk("rst_pc", pc_out, 32'hBFC00000);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_inst", if_inst, 32'h0);
      chk("rst_ifpc", if_pc, 32'hBFC00000);
      chk("rst_adel", 32'(if_adel), 32'd0);
      chk("rst_req", 32'(inst_req), 32'd0);

      // basic fetch: addr_ok immediate, data_ok one cycle later, decode accepts
      tick();
      rst = 1'b0; inst_addr_ok = 1'b1; #1;
      chk("t1_req", 32'(inst_req), 32'd1);
      chk("t1_addr", inst_addr, 32'hBFC00000);
      tick();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24080001; #1;
      chk("t1_wait_req", 32'(inst_req), 32'd0);
      chk("t1_wait_valid", 32'(if_valid), 32'd0);
      tick();
      inst_data_ok = 1'b0; id_allowin = 1'b1; #1;
      chk("t1_valid", 32'(if_valid), 32'd1);
      chk("t1_inst", if_inst, 32'h24080001);
      chk("t1_ifpc", if_pc, 32'hBFC00000);
      chk("t1_pc_hold", pc_out, 32'hBFC00000);
      tick();
      id_allowin = 1'b0; #1;
      chk("t1_valid_drop", 32'(if_valid), 32'd0);
      chk("t1_pc_next", pc_out, 32'hBFC00004);
      chk("t1_req2", 32'(inst_req), 32'd1);

      // decode stalls for 4 cycles, accepts on the 5th
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24090002;
      npc_in = 32'hBFC00008;
      tick();
      inst_data_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_valid", 32'(if_valid), 32'd1);
         chk("t2_inst", if_inst, 32'h24090002);
         chk("t2_ifpc", if_pc, 32'hBFC00004);
         chk("t2_noreq", 32'(inst_req), 32'd0);
         chk("t2_pc", pc_out, 32'hBFC00004);
         tick();
      end
      id_allowin = 1'b1;
      tick();
      id_allowin = 1'b0; #1;
      chk("t2_pc_next", pc_out, 32'hBFC00008);
      chk("t2_valid_drop", 32'(if_valid), 32'd0);

      // flush while waiting for data; late data must be dropped
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0; flush = 1'b1; npc_in = 32'hBFC00380;
      tick();
      flush = 1'b0; #1;
      chk("t3_pc", pc_out, 32'hBFC00380);
      chk("t3_cancel_noreq", 32'(inst_req), 32'd0);
      tick();
      inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF; #1;
      chk("t3_cancel_valid", 32'(if_valid), 32'd0);
      tick();
      inst_data_ok = 1'b0; #1;
      chk("t3_valid", 32'(if_valid), 32'd0);
      chk("t3_inst_kept", if_inst, 32'h24090002);
      chk("t3_req", 32'(inst_req), 32'd1);
      chk("t3_addr", inst_addr, 32'hBFC00380);
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C1D0000;
      tick();
      inst_data_ok = 1'b0; id_allowin = 1'b1; npc_in = 32'hBFC00384; #1;
      chk("t3_new_valid", 32'(if_valid), 32'd1);
      chk("t3_new_inst", if_inst, 32'h3C1D0000);
      chk("t3_new_ifpc", if_pc, 32'hBFC00380);
      tick();
      id_allowin = 1'b0;

      // flush coincident with addr_ok: next response is dropped
      inst_addr_ok = 1'b1; flush = 1'b1; npc_in = 32'hBFC00500; #1;
      chk("t4_addr", inst_addr, 32'hBFC00384);
      tick();
      inst_addr_ok = 1'b0; flush = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF; #1;
      chk("t4_noreq", 32'(inst_req), 32'd0);
      chk("t4_pc", pc_out, 32'hBFC00500);
      tick();
      inst_data_ok = 1'b0; #1;
      chk("t4_valid", 32'(if_valid), 32'd0);
      chk("t4_inst_kept", if_inst, 32'h3C1D0000);
      chk("t4_req", 32'(inst_req), 32'd1);
      chk("t4_addr2", inst_addr, 32'hBFC00500);

      // flush coincident with data_ok in S_WAIT
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF;
      flush = 1'b1; npc_in = 32'hBFC00600;
      tick();
      inst_data_ok = 1'b0; flush = 1'b0; #1;
      chk("t5_valid", 32'(if_valid), 32'd0);
      chk("t5_req", 32'(inst_req), 32'd1);
      chk("t5_addr", inst_addr, 32'hBFC00600);
      chk("t5_inst_kept", if_inst, 32'h3C1D0000);

      // misaligned PC: no request, address error reported
      flush = 1'b1; npc_in = 32'hBFC00002;
      tick();
      flush = 1'b0; #1;
      chk("t6_pc", pc_out, 32'hBFC00002);
      chk("t6_noreq", 32'(inst_req), 32'd0);
      tick();
      #1;
      chk("t6_valid", 32'(if_valid), 32'd1);
      chk("t6_adel", 32'(if_adel), 32'd1);
      chk("t6_inst", if_inst, 32'h0);
      chk("t6_ifpc", if_pc, 32'hBFC00002);
      id_allowin = 1'b1; npc_in = 32'hBFC00010;
      tick();
      id_allowin = 1'b0; #1;
      chk("t6_valid_drop", 32'(if_valid), 32'd0);
      chk("t6_pc_next", pc_out, 32'hBFC00010);
      chk("t6_req", 32'(inst_req), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach end, %0d checks made", n_checks);
      $fatal(1);
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Fetch-stage control. Owns the F-stage PC register that drives the next-PC logic's `pc` input, and loads that logic's `npc` result.
- Issues instruction reads over an SRAM-like req/addr_ok/data_ok interface and holds one fetched instruction until decode accepts it.
- Discards responses that belong to requests cancelled by a flush (interrupt/eret redirect).
- Raises an address-error flag for a misaligned PC instead of issuing a read.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- npc_in  in  32  next PC from the next-PC logic.
- flush  in  1  redirect now (int_req | eret); PC loads npc_in regardless of decode.
- id_allowin  in  1  decode can accept the held instruction this cycle.
- pc_out  out  32  current F-stage PC (to next-PC logic `pc`).
- inst_req  out  1  read request valid.
- inst_addr  out  32  read address, equals pc_out.
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  32  read data, valid with inst_data_ok.
- if_valid  out  1  if_inst/if_pc/if_adel are valid for decode.
- if_inst  out  32  fetched instruction, 0 when if_adel.
- if_pc  out  32  PC of the held instruction.
- if_adel  out  1  fetch address error (pc_out[1:0] != 0).

Behaviour:
- Reset (rst=1 at an edge) sets:
  - pc_out = RESET_PC, state = S_REQ.
  - if_valid = 0, if_inst = 0, if_pc = RESET_PC, if_adel = 0.
  - inst_req is forced to 0 while rst=1.
- Reset mid-transaction: any outstanding response is not tracked and must not occur; memory is reset together with this block.
- Combinational outputs:
  - inst_req = (state==S_REQ) & ~misaligned & ~rst.
  - inst_addr = pc_out.
  - misaligned = |pc_out[1:0].
- States:
  - S_REQ: request issuing, waiting for inst_addr_ok.
  - S_WAIT: request accepted, waiting for inst_data_ok.
  - S_VALID: instruction held, if_valid=1.
  - S_CANCEL: waiting for the data_ok of a cancelled request; that data is dropped.
- At most one request outstanding; the memory returns data in order.
- Priority each cycle: rst > flush > everything else.
- S_REQ, no flush:
  - misaligned: next state S_VALID with if_adel=1, if_inst=0, if_pc=pc_out; no request is issued.
  - inst_addr_ok=1: go to S_WAIT.
  - else: stay.
- S_REQ, flush:
  - pc_out <= npc_in.
  - If inst_addr_ok=1 in the same cycle, go to S_CANCEL; else stay in S_REQ.
  - The address may change while req is high and unaccepted.
- S_WAIT, no flush: inst_data_ok=1 latches if_inst=inst_rdata, if_pc=pc_out, if_adel=0, and goes to S_VALID.
- S_WAIT, flush:
  - pc_out <= npc_in.
  - If inst_data_ok=1 in the same cycle, drop the data and go to S_REQ; else go to S_CANCEL.
- S_VALID:
  - flush: pc_out <= npc_in, if_valid <= 0, go to S_REQ.
  - else if id_allowin=1: pc_out <= npc_in, if_valid <= 0, go to S_REQ.
  - else: hold all outputs stable.
- S_CANCEL:
  - inst_data_ok=1: go to S_REQ; if_* unchanged and if_valid stays 0.
  - flush: pc_out <= npc_in, stay unless data_ok.
- if_valid = (state==S_VALID), registered. The pipeline never sees cancelled data.
- Latency: addr_ok in cycle N, data_ok in cycle M>N, if_valid high from cycle M+1.
- Best-case throughput is one instruction per 3 cycles when addr_ok/data_ok are immediate and decode accepts at once.
- pc_out changes only on a flush, on a decode accept in S_VALID, or on reset. The next-PC logic may therefore read pc_out combinationally.

Test Plan:
- Reset release, memory gives addr_ok in the request cycle and data_ok 1 cycle later with rdata=32'h24080001, id_allowin=1 -> inst_addr=BFC00000; if_valid for 1 cycle with if_inst=24080001, if_pc=BFC00000; then pc_out=npc_in (BFC00004).
- id_allowin=0 for 4 cycles while in S_VALID -> if_valid/if_inst/if_pc stable, no inst_req, pc_out unchanged; accept on cycle 5 -> pc_out=npc_in.
- flush with npc_in=32'hBFC00380 while in S_WAIT; data_ok arrives 2 cycles later with rdata=32'hDEADBEEF -> data dropped; next request addr=BFC00380; if_inst never shows DEADBEEF.
- flush coincident with inst_addr_ok in S_REQ -> state S_CANCEL; the next data_ok is dropped; the following request uses the flush npc_in.
- flush coincident with inst_data_ok in S_WAIT -> if_valid stays 0; the next cycle issues req at npc_in.
- npc_in=32'hBFC00002 loaded -> no inst_req; next cycle if_valid=1, if_adel=1, if_inst=0, if_pc=BFC00002.
